eth_pcs_blk_lock_ctrl: RTL and testbench

Receive-side block-lock controller for the 10GBASE-R PCS, per IEEE 802.3 Clause 49 lock_state. Sits between the RX gearbox and the 66/64 descrambler/decoder path. Inspects every 2-bit sync header the gearbox delivers and issues slip requests to the gearbox until 64-header windows are clean. Asserts block lock, which downstream logic uses to qualify decoder output.

---
 rtl/eth_pcs_blk_lock_ctrl.sv | 139 +++++++++++++
 tb/tb_eth_pcs_blk_lock_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_blk_lock_ctrl.sv
// -----------------------------------------------------------------------------
// eth_pcs_blk_lock_ctrl
//   10GBASE-R receive block-lock controller. Examines every 2-bit sync header
//   delivered by the RX gearbox, asks the gearbox to slip one bit whenever the
//   alignment looks wrong, and declares block lock once a full window of
//   headers is clean. A locked link drops lock only when too many invalid
//   headers land inside a single window.
//
// Ports
//   i_clk             PCS RX clock
//   i_reset_n         asynchronous active-low reset
//   i_clk_en          gearbox clock enable; state advances only when high
//   i_grbx_hdr_valid  a new sync header is presented this enabled cycle
//   i_grbx_hdr        sync header bits
//   o_blk_lock        block lock achieved (registered)
//   o_slip            one enabled-cycle pulse: gearbox shifts alignment by a bit
//   o_slip_cnt        saturating count of slips since reset
// -----------------------------------------------------------------------------
module eth_pcs_blk_lock_ctrl #(
    parameter int unsigned       SH_WINDOW    = 64,
    parameter int unsigned       SH_INVLD_MAX = 16,
    parameter int unsigned       SLIP_WAIT    = 4,
    parameter int unsigned       W_SLIP_CNT   = 8,
    parameter int unsigned       W_SYNC       = 2,
    parameter logic [W_SYNC-1:0] SYNC_DATA    = W_SYNC'(1),
    parameter logic [W_SYNC-1:0] SYNC_CTRL    = W_SYNC'(2)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clk_en,
    input  logic                  i_grbx_hdr_valid,
    input  logic [W_SYNC-1:0]     i_grbx_hdr,
    output logic                  o_blk_lock,
    output logic                  o_slip,
    output logic [W_SLIP_CNT-1:0] o_slip_cnt
);

    localparam int unsigned W_WAIT = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        S_TEST,
        S_SLIP,
        S_WAIT
    } state_t;

    state_t                r_state;
    logic                  r_blk_lock;
    logic                  r_slip;
    logic [W_SLIP_CNT-1:0] r_slip_cnt;
    logic [6:0]            r_sh_cnt;
    logic [4:0]            r_sh_invld_cnt;
    logic [W_WAIT-1:0]     r_wait_cnt;

    logic                  w_invalid;
    logic [6:0]            w_nxt_cnt;
    logic [4:0]            w_nxt_inv;

    assign w_invalid = (i_grbx_hdr != SYNC_DATA) && (i_grbx_hdr != SYNC_CTRL);
    assign w_nxt_cnt = r_sh_cnt + 7'd1;
    assign w_nxt_inv = r_sh_invld_cnt + 5'(w_invalid);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_TEST;
            r_blk_lock     <= 1'b0;
            r_slip         <= 1'b0;
            r_slip_cnt     <= '0;
            r_sh_cnt       <= '0;
            r_sh_invld_cnt <= '0;
            r_wait_cnt     <= '0;
        end else if (i_clk_en) begin
            case (r_state)
                S_TEST: begin
                    if (i_grbx_hdr_valid) begin
                        // o_slip is raised here so that it is high for exactly
                        // the enabled cycle spent in S_SLIP.
                        if (!r_blk_lock && w_invalid) begin
                            r_state        <= S_SLIP;
                            r_slip         <= 1'b1;
                            r_sh_cnt       <= '0;
                            r_sh_invld_cnt <= '0;
                        end else if (r_blk_lock && (w_nxt_inv == 5'(SH_INVLD_MAX))) begin
                            // Checked before window end: the limit wins a tie.
                            r_state        <= S_SLIP;
                            r_slip         <= 1'b1;
                            r_blk_lock     <= 1'b0;
                            r_sh_cnt       <= '0;
                            r_sh_invld_cnt <= '0;
                        end else if (w_nxt_cnt == 7'(SH_WINDOW)) begin
                            if (w_nxt_inv == '0) begin
                                r_blk_lock <= 1'b1;
                            end
                            r_sh_cnt       <= '0;
                            r_sh_invld_cnt <= '0;
                        end else begin
                            r_sh_cnt       <= w_nxt_cnt;
                            r_sh_invld_cnt <= w_nxt_inv;
                        end
                    end
                end

                S_SLIP: begin
                    r_slip     <= 1'b0;
                    r_wait_cnt <= W_WAIT'(SLIP_WAIT);
                    r_state    <= S_WAIT;
                    if (r_slip_cnt != '1) begin
                        r_slip_cnt <= r_slip_cnt + W_SLIP_CNT'(1);
                    end
                end

                S_WAIT: begin
                    // Leave as soon as the countdown hits zero; a zero load
                    // exits without consuming any header.
                    if (r_wait_cnt == '0) begin
                        r_state        <= S_TEST;
                        r_sh_cnt       <= '0;
                        r_sh_invld_cnt <= '0;
                    end else if (i_grbx_hdr_valid) begin
                        r_wait_cnt <= r_wait_cnt - W_WAIT'(1);
                        if (r_wait_cnt == W_WAIT'(1)) begin
                            r_state        <= S_TEST;
                            r_sh_cnt       <= '0;
                            r_sh_invld_cnt <= '0;
                        end
                    end
                end

                default: begin
                    r_state <= S_TEST;
                end
            endcase
        end
    end

    assign o_blk_lock = r_blk_lock;
    assign o_slip     = r_slip;
    assign o_slip_cnt = r_slip_cnt;

endmodule

// File: tb/tb_eth_pcs_blk_lock_ctrl.sv
module tb_eth_pcs_blk_lock_ctrl;

    localparam int unsigned P_WINDOW   = 64;
    localparam int unsigned P_INV_MAX  = 16;
    localparam int unsigned P_WAIT     = 4;
    localparam int unsigned P_CNT_W    = 8;
    localparam int          CNT_SAT    = 255;

    localparam logic [1:0] G  = 2'b01;
    localparam logic [1:0] C  = 2'b10;
    localparam logic [1:0] B0 = 2'b00;
    localparam logic [1:0] B3 = 2'b11;

    logic               clk;
    logic               rst_n;
    logic               clk_en;
    logic               hdr_valid;
    logic [1:0]         hdr;
    logic               blk_lock;
    logic               slip;
    logic [P_CNT_W-1:0] slip_cnt;

    int n_checks;
    int n_errors;

    eth_pcs_blk_lock_ctrl #(
        .SH_WINDOW   (P_WINDOW),
        .SH_INVLD_MAX(P_INV_MAX),
        .SLIP_WAIT   (P_WAIT),
        .W_SLIP_CNT  (P_CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_clk_en        (clk_en),
        .i_grbx_hdr_valid(hdr_valid),
        .i_grbx_hdr      (hdr),
        .o_blk_lock      (blk_lock),
        .o_slip          (slip),
        .o_slip_cnt      (slip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the current window is a queue of "header was bad"
    // flags; realignment is a count of headers still to be skipped.
    // ------------------------------------------------------------------
    bit m_lock;
    bit m_slip;
    int m_slips;
    bit m_realign;
    int m_skip;
    bit m_win[$];

    function automatic void model_reset();
        m_lock    = 1'b0;
        m_slip    = 1'b0;
        m_slips   = 0;
        m_realign = 1'b0;
        m_skip    = 0;
        m_win.delete();
    endfunction

    function automatic void model_step(input bit en, input bit hv, input logic [1:0] h);
        bit bad;
        int nbad;
        if (!en) return;
        bad = (h == 2'b00) || (h == 2'b11);
        if (m_slip) begin
            // The slip cycle itself: header ignored, realignment starts.
            m_slip    = 1'b0;
            m_slips   = (m_slips < CNT_SAT) ? m_slips + 1 : CNT_SAT;
            m_realign = 1'b1;
            m_skip    = P_WAIT;
            return;
        end
        if (m_realign) begin
            if (m_skip == 0) begin
                m_realign = 1'b0;
                m_win.delete();
            end else if (hv) begin
                m_skip = m_skip - 1;
                if (m_skip == 0) begin
                    m_realign = 1'b0;
                    m_win.delete();
                end
            end
            return;
        end
        if (!hv) return;
        m_win.push_back(bad);
        nbad = 0;
        foreach (m_win[i]) nbad += int'(m_win[i]);
        if (!m_lock && bad) begin
            m_slip = 1'b1;
            m_win.delete();
        end else if (m_lock && nbad == P_INV_MAX) begin
            m_lock = 1'b0;
            m_slip = 1'b1;
            m_win.delete();
        end else if (m_win.size() == P_WINDOW) begin
            if (nbad == 0) m_lock = 1'b1;
            m_win.delete();
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus / checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input bit el, input bit es, input int ec);
        n_checks++;
        if (blk_lock !== el || slip !== es || slip_cnt !== ec[P_CNT_W-1:0]) begin
            n_errors++;
            $display("FAIL %s: got lock=%0b slip=%0b cnt=%0d, expected lock=%0b slip=%0b cnt=%0d",
                     nm, blk_lock, slip, slip_cnt, el, es, ec);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there.
    task automatic apply(input bit en, input bit hv, input logic [1:0] h);
        clk_en    = en;
        hdr_valid = hv;
        hdr       = h;
        @(posedge clk);
        #1;
        model_step(en, hv, h);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clk_en    = 1'b0;
        hdr_valid = 1'b0;
        hdr       = G;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst_before;
        bit         en;
        bit         hv;
        logic [1:0] h;
        int         reps;
        bit         e_lock;
        bit         e_slip;
        int         e_cnt;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit en, input bit hv, input logic [1:0] h,
                                input int reps, input bit el, input bit es, input int ec,
                                input string nm);
        vec_t v;
        v.rst_before = r;  v.en = en;  v.hv = hv;  v.h = h;  v.reps = reps;
        v.e_lock = el;     v.e_slip = es;  v.e_cnt = ec;  v.name = nm;
        tbl.push_back(v);
    endfunction

    initial begin
        int pulses;
        int rates[6];
        n_checks = 0;
        n_errors = 0;
        rst_n     = 1'b0;
        clk_en    = 1'b0;
        hdr_valid = 1'b0;
        hdr       = G;

        // ---------------- reset state ----------------
        #2;
        chk("reset_state", 1'b0, 1'b0, 0);

        // ---------------- table-driven segments ----------------
        add(1, 1, 1, G,  63, 0, 0, 0, "lock_after_63");
        add(0, 1, 1, G,   1, 1, 0, 0, "lock_after_64");
        add(1, 1, 1, C,   9, 0, 0, 0, "unlocked_9_ctrl");
        add(0, 1, 1, B3,  1, 0, 1, 0, "slip_pulse");
        add(0, 1, 1, G,   1, 0, 0, 1, "slip_done_cnt1");
        add(0, 1, 1, G,   4, 0, 0, 1, "wait_ignored");
        add(0, 1, 1, G,  63, 0, 0, 1, "relock_63");
        add(0, 1, 1, G,   1, 1, 0, 1, "relock_64");
        for (int i = 0; i < 15; i++) begin
            add(0, 1, 1, G,  3, 1, 0, 1, "scatter_good");
            add(0, 1, 1, B0, 1, 1, 0, 1, "scatter_bad");
        end
        add(0, 1, 1, G,   4, 1, 0, 1, "win_15_bad_end");
        add(0, 1, 1, C,  64, 1, 0, 1, "clean_window");
        add(0, 0, 1, B3,  5, 1, 0, 1, "disabled_hdr_ignored");
        add(0, 1, 1, G,  48, 1, 0, 1, "pre_16_good");
        add(0, 1, 1, B3, 15, 1, 0, 1, "inv_15_locked");
        add(0, 1, 1, B0,  1, 0, 1, 1, "inv16_at_window_end");
        add(0, 1, 1, G,   1, 0, 0, 2, "after_unlock_slip");

        foreach (tbl[k]) begin
            if (tbl[k].rst_before) do_reset();
            for (int r = 0; r < tbl[k].reps; r++) apply(tbl[k].en, tbl[k].hv, tbl[k].h);
            chk(tbl[k].name, tbl[k].e_lock, tbl[k].e_slip, tbl[k].e_cnt);
        end

        // ---------------- clock enable toggling ----------------
        do_reset();
        for (int i = 0; i < 63; i++) begin
            apply(1, 1, G);
            apply(0, 1, B3);
        end
        chk("en_toggle_63", 0, 0, 0);
        apply(1, 1, G);
        chk("en_toggle_64_lock", 1, 0, 0);
        // async reset while locked: clears without a clock edge
        #2 rst_n = 1'b0;
        #1 chk("async_reset_locked", 0, 0, 0);
        do_reset();
        apply(1, 1, B0);
        chk("en_slip_rise", 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, G);
            chk("en_slip_hold", 0, 1, 0);
        end
        apply(1, 1, G);
        chk("en_slip_single", 0, 0, 1);

        // ---------------- saturation and reset in S_WAIT ----------------
        do_reset();
        pulses = 0;
        for (int i = 0; i < 1800; i++) begin
            apply(1, 1, B0);
            if (slip === 1'b1) pulses++;
        end
        chk_int("slip_pulses_300", pulses, 300);
        chk("slip_cnt_saturated", 0, 0, CNT_SAT);
        apply(1, 1, B3);
        chk("slip_301_rise", 0, 1, CNT_SAT);
        apply(1, 1, B3);
        apply(1, 1, B3);
        chk("in_wait_saturated", 0, 0, CNT_SAT);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_in_wait", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            clk_en    = 1'b1;
            hdr_valid = 1'b1;
            hdr       = B0;
            @(posedge clk);
            #1 chk("no_slip_in_reset", 0, 0, 0);
        end

        // ---------------- randomized vs reference model ----------------
        rates = '{0, 300, 40, 4, 0, 60};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 600; i++) begin
                bit en, hv, bad;
                logic [1:0] h;
                en  = ($urandom_range(0, 3) != 0);
                hv  = ($urandom_range(0, 4) != 0);
                bad = (rates[s] > 0) && ($urandom_range(0, rates[s] - 1) == 0);
                if (bad) h = $urandom_range(0, 1) ? B0 : B3;
                else     h = $urandom_range(0, 1) ? G : C;
                apply(en, hv, h);
                chk("random", m_lock, m_slip, m_slips);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
